// File: rtl/irq_timer_ctrl_if.sv
// Bus between the CPU and the timer/interrupt controller: channel configuration,
// interrupt handshake and status outputs.
interface irq_timer_ctrl_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  localparam int CH_W = $clog2(N_CH);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic             cfg_mode;
  logic             cfg_en;
  logic             irq_ack;
  logic             irq_done;
  logic             irq;
  logic [CH_W-1:0]  irq_vec;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  overrun;
  logic             busy;

  modport master (
    output cfg_we, cfg_ch, cfg_period, cfg_mode, cfg_en, irq_ack, irq_done,
    input  irq, irq_vec, pending, overrun, busy
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_period, cfg_mode, cfg_en, irq_ack, irq_done,
    output irq, irq_vec, pending, overrun, busy
  );
endinterface

// File: rtl/irq_timer_ctrl.sv
// Multi-channel periodic/one-shot timer feeding a lowest-index-priority
// interrupt controller with an ack/done handshake towards the CPU.
module irq_timer_ctrl #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  irq_timer_ctrl_if.slave bus
);
  localparam int CH_W = $clog2(N_CH);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  state_e           state_q;
  logic             irq_q;
  logic [CH_W-1:0]  vec_q;

  logic [CNT_W-1:0] cnt_q    [N_CH];
  logic [CNT_W-1:0] cnt_d    [N_CH];
  logic [CNT_W-1:0] period_q [N_CH];
  logic [CNT_W-1:0] period_d [N_CH];
  logic [N_CH-1:0]  mode_q, mode_d;
  logic [N_CH-1:0]  en_q, en_d;
  logic [N_CH-1:0]  pending_q, pending_d;
  logic [N_CH-1:0]  overrun_q, overrun_d;
  logic [N_CH-1:0]  tick;
  logic [CH_W-1:0]  lowestVec;
  logic             ackTaken;

  assign ackTaken = (state_q == REQ) && bus.irq_ack;

  always_comb begin
    lowestVec = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) lowestVec = CH_W'(i);
    end
  end

  // A config write overrides the counter datapath of its channel, but a tick
  // on that same edge still sets pending, and set always beats the ack clear.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    mode_d    = mode_q;
    en_d      = en_q;
    tick      = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i]    = cnt_q[i];
      period_d[i] = period_q[i];
      tick[i]     = en_q[i] && (period_q[i] != '0) &&
                    (cnt_q[i] == period_q[i] - CNT_W'(1));
      if (tick[i]) begin
        cnt_d[i] = '0;
        if (mode_q[i]) en_d[i] = 1'b0;
      end else if (en_q[i] && (period_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      if (ackTaken && (vec_q == CH_W'(i))) pending_d[i] = 1'b0;
      if (tick[i]) begin
        pending_d[i] = 1'b1;
        if (pending_q[i]) overrun_d[i] = 1'b1;
      end
      if (bus.cfg_we && (bus.cfg_ch == CH_W'(i))) begin
        period_d[i]  = bus.cfg_period;
        mode_d[i]    = bus.cfg_mode;
        en_d[i]      = bus.cfg_en;
        cnt_d[i]     = '0;
        overrun_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]    <= '0;
        period_q[i] <= '0;
      end
      mode_q    <= '0;
      en_q      <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        period_q[i] <= period_d[i];
      end
      mode_q    <= mode_d;
      en_q      <= en_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // Priority is sampled only when leaving IDLE; the vector then stays frozen
  // through REQ and SERVICE regardless of newer or higher-priority ticks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      vec_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          irq_q <= 1'b0;
          if (|pending_q) begin
            state_q <= REQ;
            irq_q   <= 1'b1;
            vec_q   <= lowestVec;
          end
        end
        REQ: begin
          if (bus.irq_ack) begin
            state_q <= SERVICE;
            irq_q   <= 1'b0;
          end
        end
        SERVICE: begin
          irq_q <= 1'b0;
          if (bus.irq_done) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq     = irq_q;
  assign bus.irq_vec = vec_q;
  assign bus.pending = pending_q;
  assign bus.overrun = overrun_q;
  assign bus.busy    = (state_q != IDLE);
endmodule
